// File: rtl/decode_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : decode_if                                              |
// | Brief   : Fetch, write-back and ID/EX signal bundle for decode.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface decode_if;
    logic [31:0] ir_i;
    logic [31:0] npc_i;
    logic        if_valid_i;
    logic        ex_stall_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        stall_o;
    logic        pc_update_o;
    logic [31:0] pc_o;
    logic        id_valid_o;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_o;
    logic [5:0]  op_o;
    logic [5:0]  funct_o;
    logic [31:0] npc_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic        reg_wr_o;

    modport master (
        output ir_i, npc_i, if_valid_i, ex_stall_i, wb_we_i, wb_addr_i, wb_data_i,
        input  stall_o, pc_update_o, pc_o, id_valid_o, a_o, b_o, imm_o, rd_o,
               op_o, funct_o, npc_o, mem_rd_o, mem_wr_o, reg_wr_o
    );

    modport slave (
        input  ir_i, npc_i, if_valid_i, ex_stall_i, wb_we_i, wb_addr_i, wb_data_i,
        output stall_o, pc_update_o, pc_o, id_valid_o, a_o, b_o, imm_o, rd_o,
               op_o, funct_o, npc_o, mem_rd_o, mem_wr_o, reg_wr_o
    );
endinterface
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : decode                                                 |
// | Brief   : ID stage: regfile with WB bypass, branch resolve,      |
// |           load-use hazard detect, squash, ID/EX register.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module decode #(
    parameter int RF_DEPTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    decode_if.slave   bus
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_J     = 6'h02;

    logic [31:0] r_rf [RF_DEPTH];
    logic        r_squash;
    logic        r_id_valid;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_reg_wr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_npc;
    logic [4:0]  r_rd;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_imm;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_rd;
    logic        w_reg_wr;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_uses_rt;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_dec_valid;
    logic        w_hazard;
    logic        w_pc_update;

    assign w_op  = bus.ir_i[31:26];
    assign w_rs  = bus.ir_i[25:21];
    assign w_rt  = bus.ir_i[20:16];
    assign w_imm = {{16{bus.ir_i[15]}}, bus.ir_i[15:0]};

    // Write-first: a same-cycle write-back to the read address wins over the array
    always_comb begin
        w_a = '0;
        w_b = '0;
        if (w_rs != 5'd0) begin
            w_a = (bus.wb_we_i && bus.wb_addr_i == w_rs) ? bus.wb_data_i : r_rf[w_rs];
        end
        if (w_rt != 5'd0) begin
            w_b = (bus.wb_we_i && bus.wb_addr_i == w_rt) ? bus.wb_data_i : r_rf[w_rt];
        end
    end

    always_comb begin
        w_rd      = 5'd0;
        w_reg_wr  = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_uses_rt = 1'b0;
        w_taken   = 1'b0;
        w_target  = bus.npc_i + {w_imm[29:0], 2'b00};
        case (w_op)
            c_OP_RTYPE: begin
                w_rd      = bus.ir_i[15:11];
                w_reg_wr  = 1'b1;
                w_uses_rt = 1'b1;
            end
            c_OP_ADDI: begin
                w_rd     = w_rt;
                w_reg_wr = 1'b1;
            end
            c_OP_LW: begin
                w_rd     = w_rt;
                w_reg_wr = 1'b1;
                w_mem_rd = 1'b1;
            end
            c_OP_SW: begin
                w_mem_wr  = 1'b1;
                w_uses_rt = 1'b1;
            end
            c_OP_BEQ: begin
                w_uses_rt = 1'b1;
                w_taken   = (w_a == w_b);
            end
            c_OP_BNE: begin
                w_uses_rt = 1'b1;
                w_taken   = (w_a != w_b);
            end
            c_OP_J: begin
                w_taken  = 1'b1;
                w_target = {bus.npc_i[31:28], bus.ir_i[25:0], 2'b00};
            end
            default: begin
                w_rd = 5'd0;
            end
        endcase
    end

    assign w_dec_valid = bus.if_valid_i && !r_squash;
    assign w_hazard    = r_id_valid && r_mem_rd && (r_rd != 5'd0) &&
                         ((r_rd == w_rs) || (w_uses_rt && (r_rd == w_rt)));
    assign w_pc_update = rst && w_dec_valid && w_taken && !w_hazard && !bus.ex_stall_i;

    assign bus.pc_update_o = w_pc_update;
    assign bus.pc_o        = w_pc_update ? w_target : 32'd0;
    assign bus.stall_o     = rst && (bus.ex_stall_i || (w_dec_valid && w_hazard));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.wb_we_i && bus.wb_addr_i != 5'd0) begin
            r_rf[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    // The wrong-path slot is consumed only when fetch actually advances
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_squash <= 1'b0;
        end else if (w_pc_update) begin
            r_squash <= 1'b1;
        end else if (r_squash && bus.if_valid_i && !bus.ex_stall_i) begin
            r_squash <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id_valid <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_npc      <= '0;
            r_rd       <= '0;
            r_op       <= '0;
            r_funct    <= '0;
        end else if (!bus.ex_stall_i) begin
            if (w_hazard) begin
                r_id_valid <= 1'b0;
                r_mem_rd   <= 1'b0;
                r_mem_wr   <= 1'b0;
                r_reg_wr   <= 1'b0;
            end else begin
                r_id_valid <= w_dec_valid;
                r_mem_rd   <= w_dec_valid && w_mem_rd;
                r_mem_wr   <= w_dec_valid && w_mem_wr;
                r_reg_wr   <= w_dec_valid && w_reg_wr;
                r_a        <= w_a;
                r_b        <= w_b;
                r_imm      <= w_imm;
                r_npc      <= bus.npc_i;
                r_rd       <= w_rd;
                r_op       <= w_op;
                r_funct    <= bus.ir_i[5:0];
            end
        end
    end

    assign bus.id_valid_o = r_id_valid;
    assign bus.a_o        = r_a;
    assign bus.b_o        = r_b;
    assign bus.imm_o      = r_imm;
    assign bus.rd_o       = r_rd;
    assign bus.op_o       = r_op;
    assign bus.funct_o    = r_funct;
    assign bus.npc_o      = r_npc;
    assign bus.mem_rd_o   = r_mem_rd;
    assign bus.mem_wr_o   = r_mem_wr;
    assign bus.reg_wr_o   = r_reg_wr;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_decode                                              |
// | Brief   : Directed plus randomized bench for decode with a       |
// |           behavioural reference model.                           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_decode;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_if bus ();

    decode #(.RF_DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_rf [32];
    logic        m_squash = 1'b0;
    logic        m_v = 1'b0, m_mrd = 1'b0, m_mwr = 1'b0, m_rwr = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_imm = '0, m_npc = '0;
    logic [4:0]  m_rd = '0;
    logic [5:0]  m_op = '0, m_fn = '0;
    int          m_chk = 0;  // 0 nothing known, 1 valid bit, 2 +control bits, 3 every field
    logic        e_stall = 1'b0, e_pcu = 1'b0;
    logic        s_stall = 1'b0, s_pcu = 1'b0;
    logic [31:0] s_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ad);
        if (ad == 5'd0) return 32'd0;
        if (bus.wb_we_i && bus.wb_addr_i == ad) return bus.wb_data_i;
        return m_rf[ad];
    endfunction

    // One clock: drive at negedge, compare against the model, advance the model, pass the edge
    task automatic cycle(input logic r, input logic v, input logic xs,
                         input logic [31:0] ir, input logic [31:0] npc,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [4:0]  rs, rt, drd;
        logic [5:0]  op;
        logic [31:0] a, b, imm, tgt;
        logic        uses_rt, hz, dv, tk, wr, mr, mw;
        @(negedge clk);
        rst = r;
        bus.if_valid_i = v;
        bus.ex_stall_i = xs;
        bus.ir_i = ir;
        bus.npc_i = npc;
        bus.wb_we_i = we;
        bus.wb_addr_i = wa;
        bus.wb_data_i = wd;
        #1;
        op = ir[31:26];
        rs = ir[25:21];
        rt = ir[20:16];
        a = m_read(rs);
        b = m_read(rt);
        imm = {{16{ir[15]}}, ir[15:0]};
        uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        hz = m_v && m_mrd && (m_rd != 5'd0) && ((m_rd == rs) || (uses_rt && m_rd == rt));
        dv = v && !m_squash;
        tk = (op == 6'h04 && a == b) || (op == 6'h05 && a != b) || (op == 6'h02);
        tgt = (op == 6'h02) ? {npc[31:28], ir[25:0], 2'b00} : npc + (imm << 2);
        e_pcu = r && dv && tk && !hz && !xs;
        e_stall = r && (xs || (dv && hz));
        s_stall = bus.stall_o;
        s_pcu = bus.pc_update_o;
        s_pc = bus.pc_o;

        if (m_chk > 0) chk("id_valid", bus.id_valid_o, m_v);
        if (m_chk >= 2) begin
            chk("mem_rd", bus.mem_rd_o, m_mrd);
            chk("mem_wr", bus.mem_wr_o, m_mwr);
            chk("reg_wr", bus.reg_wr_o, m_rwr);
        end
        if (m_chk >= 3) begin
            chk("a", bus.a_o, m_a);
            chk("b", bus.b_o, m_b);
            chk("imm", bus.imm_o, m_imm);
            chk("rd", bus.rd_o, m_rd);
            chk("op", bus.op_o, m_op);
            chk("funct", bus.funct_o, m_fn);
            chk("npc", bus.npc_o, m_npc);
        end
        chk("stall", s_stall, e_stall);
        chk("pc_update", s_pcu, e_pcu);
        if (e_pcu || !r) chk("pc", s_pc, e_pcu ? tgt : 32'd0);

        drd = 5'd0; wr = 1'b0; mr = 1'b0; mw = 1'b0;
        case (op)
            6'h00: begin drd = ir[15:11]; wr = 1'b1; end
            6'h08: begin drd = rt; wr = 1'b1; end
            6'h23: begin drd = rt; wr = 1'b1; mr = 1'b1; end
            6'h2B: mw = 1'b1;
            default: drd = 5'd0;
        endcase

        if (!r) begin
            m_v = 0; m_mrd = 0; m_mwr = 0; m_rwr = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_npc = 0; m_rd = 0; m_op = 0; m_fn = 0;
            m_chk = 3;
            m_squash = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (!xs) begin
                if (hz) begin
                    m_v = 0; m_mrd = 0; m_mwr = 0; m_rwr = 0;
                    m_chk = 2;
                end else begin
                    m_v = dv;
                    m_a = a; m_b = b; m_imm = imm; m_npc = npc;
                    m_rd = drd; m_op = op; m_fn = ir[5:0];
                    m_mrd = dv && mr; m_mwr = dv && mw; m_rwr = dv && wr;
                    m_chk = dv ? 3 : ((m_squash && v) ? 2 : 1);
                end
            end
            if (e_pcu) m_squash = 1'b1;
            else if (m_squash && v && !xs) m_squash = 1'b0;
            if (we && wa != 5'd0) m_rf[wa] = wd;
        end
        @(posedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] im;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        im = 16'($urandom());
        case ($urandom_range(0, 7))
            0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1: return {6'h08, rs, rt, im};
            2: return {6'h23, rs, rt, im};
            3: return {6'h2B, rs, rt, im};
            4: return {6'h04, rs, rt, im};
            5: return {6'h05, rs, rt, im};
            6: return {6'h02, 26'($urandom())};
            default: return {6'h3F, 26'($urandom())};
        endcase
    endfunction

    initial begin
        logic [31:0] cur_ir, cur_npc, wd;
        logic        cur_v, last_stall, xs, rr, we;
        logic [4:0]  wa;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        bus.ir_i = '0; bus.npc_i = '0; bus.if_valid_i = 0; bus.ex_stall_i = 0;
        bus.wb_we_i = 0; bus.wb_addr_i = '0; bus.wb_data_i = '0;

        // Reset held for 5 cycles with busy inputs
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h10220003, 32'h104, 1, 5'd3, 32'h55);
        #2;
        chk("rst id_valid", bus.id_valid_o, 0);
        chk("rst a", bus.a_o, 0);

        // r1..r31 read zero after reset
        for (int k = 1; k < 32; k++)
            cycle(1, 1, 0, {6'h00, 5'(k), 5'd0, 5'd5, 5'd0, 6'h25}, 32'h100 + 32'(4 * k), 0, 0, 0);

        // Write-back bypass
        cycle(1, 1, 0, 32'h00602020, 32'h200, 1, 5'd3, 32'hDEADBEEF);
        #2;
        chk("bypass a", bus.a_o, 32'hDEADBEEF);
        chk("bypass rd", bus.rd_o, 32'd4);
        chk("bypass reg_wr", bus.reg_wr_o, 1);

        // Register 0 ignores writes and bypass
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 5'd0, 32'h1234);
        cycle(1, 1, 0, 32'h00002825, 32'h204, 1, 5'd0, 32'h1234);
        #2;
        chk("r0 a", bus.a_o, 0);

        // Load-use: lw $2,0($1) then add $3,$2,$2
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 5'd1, 32'h100);
        cycle(1, 1, 0, 32'h8C220000, 32'h300, 0, 0, 0);
        cycle(1, 1, 0, 32'h00421820, 32'h304, 0, 0, 0);
        chk("lu stall", s_stall, 1);
        #2;
        chk("lu bubble", bus.id_valid_o, 0);
        cycle(1, 1, 0, 32'h00421820, 32'h304, 0, 0, 0);
        chk("lu stall clear", s_stall, 0);
        #2;
        chk("lu add valid", bus.id_valid_o, 1);
        chk("lu add rd", bus.rd_o, 32'd3);

        // Taken beq $1,$2,+3 at npc 0x104
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 5'd1, 32'd7);
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 5'd2, 32'd7);
        cycle(1, 1, 0, 32'h10220003, 32'h104, 0, 0, 0);
        chk("beq pc_update", s_pcu, 1);
        chk("beq pc", s_pc, 32'h110);
        #2;
        chk("beq valid", bus.id_valid_o, 1);
        chk("beq reg_wr", bus.reg_wr_o, 0);
        cycle(1, 1, 0, 32'h00421820, 32'h110, 0, 0, 0);
        #2;
        chk("squashed", bus.id_valid_o, 0);

        // Downstream hold over bne $1,$3,-1 at npc 0x300 (r1=7, r3=5)
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 5'd3, 32'd5);
        cycle(1, 1, 0, 32'h20060009, 32'h2FC, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 32'h1423FFFF, 32'h300, 0, 0, 0);
            chk("hold stall", s_stall, 1);
            chk("hold pc_update", s_pcu, 0);
            #2;
            chk("hold valid", bus.id_valid_o, 1);
            chk("hold rd", bus.rd_o, 32'd6);
        end
        cycle(1, 1, 0, 32'h1423FFFF, 32'h300, 0, 0, 0);
        chk("bne pc_update", s_pcu, 1);
        chk("bne pc", s_pc, 32'h2FC);

        // Reset mid-redirect discards the pending squash
        cycle(1, 1, 0, 32'h20060009, 32'h2FC, 0, 0, 0);
        cycle(1, 1, 0, {6'h02, 26'h0000040}, 32'h1000, 0, 0, 0);
        chk("j pc", s_pc, 32'h100);
        cycle(0, 1, 0, 32'h20060009, 32'h100, 0, 0, 0);
        cycle(1, 1, 0, 32'h20060009, 32'h104, 0, 0, 0);
        #2;
        chk("post-reset valid", bus.id_valid_o, 1);

        // Randomized traffic with fetch honoring stall_o
        last_stall = 1'b0;
        cur_ir = '0; cur_npc = '0; cur_v = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                cur_v = ($urandom_range(0, 9) != 0);
                cur_ir = rand_instr();
                cur_npc = $urandom() & 32'hFFFF_FFFC;
            end
            xs = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 299) != 0);
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 7));
            wd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            cycle(rr, cur_v, xs, cur_ir, cur_npc, we, wa, wd);
            last_stall = e_stall;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode.md
# decode

Instruction-decode stage between `fetch` and execute. Consumes the fetched instruction word and next-PC, reads a 32×32 register file with write-back bypass, and resolves branches and jumps by driving `fetch`'s PC redirect (`pc_update`/`pc_i`). Detects load-use hazards and squashes the wrong-path instruction after a redirect. Latches decoded operands into the ID/EX pipeline register.

## Interface
- `RF_DEPTH`, 32: register count; index width is fixed at 5.
- `rst` in 1: reset, synchronous, active-low.
- `clk` in 1: clock; all state updates on the rising edge.
- `ir_i` in 32: instruction word from `fetch` (`ir_o`).
- `npc_i` in 32: PC+4 of `ir_i`, from `fetch` (`npc`).
- `if_valid_i` in 1: `ir_i`/`npc_i` valid this cycle.
- `ex_stall_i` in 1: execute stage cannot accept; hold ID/EX.
- `wb_we_i` in 1: register write enable from write-back.
- `wb_addr_i` in 5: write-back destination.
- `wb_data_i` in 32: write-back data.
- `stall_o` out 1: fetch must hold `ir_i`/`npc_i` next cycle.
- `pc_update_o` out 1: redirect fetch; connects to `fetch.pc_update`.
- `pc_o` out 32: redirect target; connects to `fetch.pc_i`.
- `id_valid_o` out 1: ID/EX contents valid.
- `a_o`, `b_o` out 32: rs and rt operand values.
- `imm_o` out 32: sign-extended imm16.
- `rd_o` out 5: destination register (rd for R-type, rt for I-type, 0 for sw/beq/bne/j).
- `op_o` out 6, `funct_o` out 6: opcode and funct fields.
- `npc_o` out 32: forwarded `npc_i`.
- `mem_rd_o`, `mem_wr_o`, `reg_wr_o` out 1: control bits for lw, sw, and register-writing instructions.

## Operation
- Supported opcodes: R-type 0x00, addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- Unknown opcode decodes as a NOP: `reg_wr_o`, `mem_rd_o`, and `mem_wr_o` are 0, and no redirect is issued.
- Register file:
  - Write on the rising edge when `wb_we_i` is 1 and `wb_addr_i` is not 0.
  - Register 0 always reads 0.
  - Write-first bypass: a read of `wb_addr_i` in the same cycle as its write returns `wb_data_i`.
- Decode is valid when `if_valid_i` is 1 and the `squash` flag is 0.
- Load-use hazard: ID/EX is valid with `mem_rd_o`=1, `rd_o` is not 0, and `rd_o` equals the current rs, or the current rt for R-type/sw/beq/bne.
- Redirect (combinational):
  - beq is taken when a==b; bne is taken when a!=b.
  - Branch target = `npc_i` + (sext(imm16)<<2), mod 2^32.
  - j is always taken; target = {`npc_i`[31:28], ir[25:0], 2'b00}.
  - `pc_update_o` = decode valid & taken & no hazard & `ex_stall_i`=0.
- Branch operands come from the register file and bypass only. RAW distance of 1–2 instructions to a branch is software's responsibility (insert NOPs).
- `stall_o` = `ex_stall_i` | (decode valid & load-use hazard).
- ID/EX update, in priority order:
  1. `rst`=0: clear all ID/EX registers.
  2. `ex_stall_i`=1: hold.
  3. Load-use hazard: bubble (`id_valid_o`=0, all control bits 0).
  4. Otherwise: latch the decode result; `id_valid_o` = decode valid.
- `squash` flag:
  - Set on the edge where `pc_update_o`=1.
  - Cleared on the next edge where `if_valid_i`=1 and `ex_stall_i`=0; that instruction enters ID/EX as a bubble.
  - Does not assert `stall_o`.
- Redirected branch/jump: enters ID/EX as valid with `reg_wr_o`=0.

## Timing
- Reset: every output is 0, `squash`=0, and all registers are 0. Reset asserted mid-operation clears everything on that edge and discards any in-progress redirect and squash.
- Decode-to-ID/EX latency: 1 cycle.
- `pc_update_o`/`pc_o`: same cycle as the branch in decode, so fetch loads the target on the next edge.
- Load-use stall: exactly 1 bubble. The next cycle the lw is no longer in ID/EX, so the hazard clears.
- `ex_stall_i` and a hazard in the same cycle: hold wins; no bubble is inserted until `ex_stall_i` drops.
- Redirect during a hazard is suppressed and re-evaluated after the stall.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 for 5 cycles, then release.
  - Required: all outputs are 0. A read of r1..r31 returns 0.
- Write-back bypass:
  - Stimulus: `wb_we_i`=1, `wb_addr_i`=3, `wb_data_i`=0xDEADBEEF. Same cycle, `ir_i`=add $4,$3,$0 (0x00602020).
  - Required, next cycle: `a_o`=0xDEADBEEF, `rd_o`=4, `reg_wr_o`=1.
- Register 0:
  - Stimulus: write 0x1234 to r0, then decode or $5,$0,$0.
  - Required: `a_o`=0.
- Load-use:
  - Stimulus: lw $2,0($1), then add $3,$2,$2.
  - Required: `stall_o`=1 for one cycle; one bubble (`id_valid_o`=0); the add latches on the following edge.
- Taken branch:
  - Stimulus: r1=r2=7; beq $1,$2,+3 at `npc_i`=0x104.
  - Required: `pc_update_o`=1 and `pc_o`=0x110 that cycle. The next valid instruction is squashed (`id_valid_o`=0).
- Downstream hold:
  - Stimulus: `ex_stall_i`=1 for 3 cycles during a bne.
  - Required: ID/EX is unchanged, `stall_o`=1, and `pc_update_o`=0 throughout. The redirect fires when `ex_stall_i` drops.
